stack_frame_ctrl: RTL
=====================

# stack_frame_ctrl

Call-frame sequencer that sits between the core's execution unit and a `SuperStack` instance, acting as that stack's sole initiator. It accepts push/pop/replace/call/return commands over a valid/ready handshake and translates them into one-cycle `SuperStack` op/data/underflow_limit drives. It keeps a shadow depth counter and a LIFO of saved underflow limits (frame records), and checks every stack status against the expected value. It enforces frame boundaries before issuing any op, so the stack never sees an illegal request.

## Interface
Parameters:
- `WIDTH`, 8: data word width; must match the attached stack.
- `DEPTH`, 1: stack depth exponent; stack capacity CAP = 2^(DEPTH+1)-1; index width DEPTH+1.
- `FRAMES`, 1: frame-record LIFO holds 2^FRAMES saved limits.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high; the same signal also resets the attached stack.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 3: NOP, PUSH, POP, REPLACE, CALL, RETURN.
- `cmd_data` in WIDTH: PUSH/REPLACE operand.
- `cmd_count` in DEPTH+1: argument count for CALL, result count (0/1) for RETURN.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 3: error code, valid with `rsp_valid`.
- `rsp_tos` out WIDTH: `stk_tos` sampled at completion.
- `stk_op` out 2: `SuperStack` op (NONE/PUSH/POP/REPLACE codes).
- `stk_data` out WIDTH: data to stack.
- `stk_underflow_limit` out DEPTH+1: current frame base L.
- `stk_tos` in WIDTH: stack top.
- `stk_status` in 2: stack status.
- `depth` out DEPTH+1: shadow depth D.
- `frame_level` out FRAMES+1: number of saved records.

## Operation
- Reset: state IDLE; D=0, L=0, `frame_level`=0, `stk_op`=NONE, `stk_data`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_tos`=0, `cmd_ready`=1 from the next cycle.
- Error codes: 0 OK, 1 OVERFLOW, 2 UNDERFLOW, 3 FRAME_OVF, 4 FRAME_UNF, 5 ARGS, 6 UNWIND, 7 DESYNC.
- Errors detected at acceptance issue no stack op and change no state. Response follows the normal latency with `stk_op`=NONE.
  - PUSH with D==CAP: OVERFLOW.
  - POP or REPLACE with D==L: UNDERFLOW.
  - CALL with a full record LIFO: FRAME_OVF.
  - CALL with count > D-L: ARGS.
  - RETURN with `frame_level`==0: FRAME_UNF.
  - RETURN with count>1 or count > D-L: ARGS.
- PUSH/POP: D ±1. REPLACE and NOP: D unchanged.
- CALL: push L onto records; L ← D-count; `stk_op`=NONE.
- RETURN: A = D-L.
  - If count==1, latch `stk_tos` at acceptance.
  - UNWIND: issue A POPs, one per cycle.
  - RESTORE: L ← popped record; issue PUSH of the latched value if count==1, else NONE.
- States: IDLE → ISSUE → CHECK → IDLE. RETURN takes IDLE → UNWIND (skipped if A==0) → RESTORE → CHECK.
- CHECK compares `stk_status` with the expected status: EMPTY if D==L, else NONE. On mismatch, `rsp_err`=DESYNC; D and L keep their computed values.
- All depth arithmetic is unsigned DEPTH+1 bits. Preconditions guarantee no wrap.

## Timing
- Cycle 0 is the cycle in which `cmd_valid` and `cmd_ready` are both high.
- Simple commands and CALL:
  - Cycle 1: `stk_op`/`stk_data`/`stk_underflow_limit` driven.
  - Cycle 2: `rsp_valid`, `cmd_ready` low.
  - Cycle 3: IDLE.
- RETURN:
  - Cycles 1..A: POP.
  - Cycle A+1: RESTORE.
  - Cycle A+2: `rsp_valid`.
- `stk_op` returns to NONE in every cycle it is not issuing.
- `cmd_ready` is low from cycle 1 through the response cycle.
- Reset mid-operation: abort immediately to the reset state; no response is emitted.

## Configuration
- `STACK_FRAME_UNWIND_EN` defined: RETURN discards locals via the UNWIND pop loop, as described above.
- `STACK_FRAME_UNWIND_EN` undefined:
  - No UNWIND state.
  - RETURN requires A==count, else error UNWIND with no state change.
  - RESTORE drives NONE with the restored limit; the result stays in place.
  - Response in cycle 2.

## Structure
- Shared header `stack_frame.vh`: command codes, error codes, state encodings. Stack op and status codes come from `stack.vh`.
- Sub-module `frame_lifo`: 2^FRAMES × (DEPTH+1) register LIFO with push/pop/full/empty/level.

## Test plan
WIDTH=8, DEPTH=2 (CAP=7), FRAMES=1, `STACK_FRAME_UNWIND_EN` defined unless stated.
- Reset; PUSH 0x11, PUSH 0x22 → each `rsp_valid` in cycle 2, err 0; second `rsp_tos`=0x22; D=2; `stk_status` NONE.
- After reset, POP → err UNDERFLOW; `stk_op` stays NONE; D=0. REPLACE 0x44 → UNDERFLOW.
- Push 7 items, 8th PUSH 0x99 → OVERFLOW; `rsp_tos` unchanged; D=7.
- Push 1,2,3; CALL count 2 → L=1, `frame_level`=1. POP, POP → OK, second gives `stk_status` EMPTY. Third POP → UNDERFLOW. Two CALLs then a third → FRAME_OVF.
- D=5, L=1, top 0x55; RETURN count 1 → POPs in cycles 1–4, PUSH 0x55 in cycle 5, `rsp_valid` in cycle 6; D=2, L=0, `rsp_tos`=0x55. Macro undefined, same case → UNWIND error, D/L unchanged.
- Assert reset in cycle 2 of an unwinding RETURN → next cycle all outputs at reset values, no `rsp_valid`, `cmd_ready`=1.

Source files
------------

// File: rtl/stack_frame_pkg.sv
// stack_frame_pkg: shared encodings for the call-frame sequencer.
//   cmd_op_e       : command codes on cmd_op
//   err_e          : response error codes on rsp_err
//   stk_op_e       : op codes driven to the attached SuperStack
//   stk_status_e   : status codes reported by the attached SuperStack
//   state_e        : sequencer FSM states
package stack_frame_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_PUSH    = 3'd1,
        CMD_POP     = 3'd2,
        CMD_REPLACE = 3'd3,
        CMD_CALL    = 3'd4,
        CMD_RETURN  = 3'd5
    } cmd_op_e;

    typedef enum logic [2:0] {
        ERR_OK        = 3'd0,
        ERR_OVERFLOW  = 3'd1,
        ERR_UNDERFLOW = 3'd2,
        ERR_FRAME_OVF = 3'd3,
        ERR_FRAME_UNF = 3'd4,
        ERR_ARGS      = 3'd5,
        ERR_UNWIND    = 3'd6,
        ERR_DESYNC    = 3'd7
    } err_e;

    typedef enum logic [1:0] {
        STK_NONE    = 2'd0,
        STK_PUSH    = 2'd1,
        STK_POP     = 2'd2,
        STK_REPLACE = 2'd3
    } stk_op_e;

    typedef enum logic [1:0] {
        STS_NONE  = 2'd0,
        STS_EMPTY = 2'd1,
        STS_FULL  = 2'd2,
        STS_ERROR = 2'd3
    } stk_status_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_UNWIND  = 3'd2,
        S_RESTORE = 3'd3,
        S_CHECK   = 3'd4
    } state_e;

endpackage

// File: rtl/stack_frame_ctrl_lifo.sv
// frame_lifo: register LIFO of saved underflow limits (frame records).
//   clk, reset     : clock, synchronous active-high reset
//   push, push_data: store a record (ignored when full)
//   pop            : discard the top record (ignored when empty)
//   top            : most recently pushed record
//   full, empty    : occupancy flags
//   level          : number of stored records (0 .. 2^FRAMES)
module frame_lifo #(
    parameter int unsigned DW     = 2,
    parameter int unsigned FRAMES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [DW-1:0]   push_data,
    output logic [DW-1:0]   top,
    output logic            full,
    output logic            empty,
    output logic [FRAMES:0] level
);

    localparam logic [FRAMES:0] SLOTS = (FRAMES+1)'(2**FRAMES);
    localparam logic [FRAMES:0] ONE   = (FRAMES+1)'(1);

    logic [DW-1:0]   mem_q [0:2**FRAMES-1];
    logic [FRAMES:0] level_q;
    logic [FRAMES:0] top_idx;

    assign top_idx = level_q - ONE;
    assign top     = mem_q[top_idx[FRAMES-1:0]];
    assign full    = (level_q == SLOTS);
    assign empty   = (level_q == '0);
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else if (push && !full) begin
            level_q <= level_q + ONE;
        end else if (pop && !empty) begin
            level_q <= level_q - ONE;
        end
    end

    // Record storage needs no reset: only slots below level_q are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[level_q[FRAMES-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/stack_frame_ctrl.sv
// stack_frame_ctrl: call-frame sequencer, sole initiator of a SuperStack.
// Accepts PUSH/POP/REPLACE/CALL/RETURN over valid/ready, drives one-cycle
// stack ops, tracks shadow depth D and frame base L, and checks stack status.
//   cmd_*    : command handshake (cmd_ready high only in IDLE)
//   rsp_*    : one-cycle completion pulse with error code and stack top
//   stk_*    : SuperStack op/data/underflow_limit drive, tos/status return
//   depth    : shadow depth D        frame_level : saved frame records
// Build option STACK_FRAME_UNWIND_EN: RETURN pops the callee's locals one per
// cycle; without it RETURN requires exactly `count` live items in the frame.
module stack_frame_ctrl
    import stack_frame_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned FRAMES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [DEPTH:0]    cmd_count,
    output logic              rsp_valid,
    output logic [2:0]        rsp_err,
    output logic [WIDTH-1:0]  rsp_tos,
    output logic [1:0]        stk_op,
    output logic [WIDTH-1:0]  stk_data,
    output logic [DEPTH:0]    stk_underflow_limit,
    input  logic [WIDTH-1:0]  stk_tos,
    input  logic [1:0]        stk_status,
    output logic [DEPTH:0]    depth,
    output logic [FRAMES:0]   frame_level
);

    localparam logic [DEPTH:0] CAP = '1;
    localparam logic [DEPTH:0] ONE = (DEPTH+1)'(1);

    state_e            state_q;
    logic [DEPTH:0]    d_q, l_q;
    err_e              err_q, acc_err;
    stk_op_e           stk_op_q;
    logic [WIDTH-1:0]  stk_data_q, rsp_tos_q;
`ifdef STACK_FRAME_UNWIND_EN
    logic [DEPTH:0]    cnt_q;
    logic [WIDTH-1:0]  ret_val_q;
    logic              ret_push_q;
`endif

    cmd_op_e           op;
    logic              accept;
    logic [DEPTH:0]    avail;
    logic              lifo_push, lifo_pop, lifo_full, lifo_empty;
    logic [DEPTH:0]    lifo_top;
    stk_status_e       exp_status;

    assign op     = cmd_op_e'(cmd_op);
    assign accept = cmd_valid && (state_q == S_IDLE);
    assign avail  = d_q - l_q;

    // Frame-boundary checks made before any op reaches the stack.
    always_comb begin
        acc_err = ERR_OK;
        case (op)
            CMD_PUSH:    if (d_q == CAP) acc_err = ERR_OVERFLOW;
            CMD_POP,
            CMD_REPLACE: if (d_q == l_q) acc_err = ERR_UNDERFLOW;
            CMD_CALL: begin
                if (lifo_full)              acc_err = ERR_FRAME_OVF;
                else if (cmd_count > avail) acc_err = ERR_ARGS;
            end
            CMD_RETURN: begin
                if (lifo_empty)                                 acc_err = ERR_FRAME_UNF;
                else if (cmd_count > ONE || cmd_count > avail)  acc_err = ERR_ARGS;
`ifndef STACK_FRAME_UNWIND_EN
                else if (cmd_count != avail)                    acc_err = ERR_UNWIND;
`endif
            end
            default: acc_err = ERR_OK;
        endcase
    end

    assign lifo_push = accept && (op == CMD_CALL) && (acc_err == ERR_OK);
    // The record is popped on the edge that enters RESTORE, so L is restored
    // for the RESTORE cycle itself.
`ifdef STACK_FRAME_UNWIND_EN
    assign lifo_pop = (accept && (op == CMD_RETURN) && (acc_err == ERR_OK) && (avail == '0))
                   || ((state_q == S_UNWIND) && (cnt_q == ONE));
`else
    assign lifo_pop = accept && (op == CMD_RETURN) && (acc_err == ERR_OK);
`endif

    frame_lifo #(
        .DW     (DEPTH+1),
        .FRAMES (FRAMES)
    ) u_lifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lifo_push),
        .pop       (lifo_pop),
        .push_data (l_q),
        .top       (lifo_top),
        .full      (lifo_full),
        .empty     (lifo_empty),
        .level     (frame_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            d_q        <= '0;
            l_q        <= '0;
            err_q      <= ERR_OK;
            stk_op_q   <= STK_NONE;
            stk_data_q <= '0;
            rsp_tos_q  <= '0;
`ifdef STACK_FRAME_UNWIND_EN
            cnt_q      <= '0;
            ret_val_q  <= '0;
            ret_push_q <= 1'b0;
`endif
        end else begin
            stk_op_q <= STK_NONE;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        err_q   <= acc_err;
                        state_q <= S_ISSUE;
                        if (acc_err == ERR_OK) begin
                            case (op)
                                CMD_PUSH: begin
                                    stk_op_q   <= STK_PUSH;
                                    stk_data_q <= cmd_data;
                                    d_q        <= d_q + ONE;
                                end
                                CMD_POP: begin
                                    stk_op_q <= STK_POP;
                                    d_q      <= d_q - ONE;
                                end
                                CMD_REPLACE: begin
                                    stk_op_q   <= STK_REPLACE;
                                    stk_data_q <= cmd_data;
                                end
                                CMD_CALL: l_q <= d_q - cmd_count;
                                CMD_RETURN: begin
`ifdef STACK_FRAME_UNWIND_EN
                                    if (avail == '0) begin
                                        state_q <= S_RESTORE;
                                        l_q     <= lifo_top;
                                    end else begin
                                        // First POP issues in cycle 1; cnt_q counts pops still owed including it.
                                        state_q    <= S_UNWIND;
                                        stk_op_q   <= STK_POP;
                                        d_q        <= d_q - ONE;
                                        cnt_q      <= avail;
                                        ret_val_q  <= stk_tos;
                                        ret_push_q <= (cmd_count == ONE);
                                    end
`else
                                    state_q <= S_RESTORE;
                                    l_q     <= lifo_top;
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                end
`ifdef STACK_FRAME_UNWIND_EN
                S_UNWIND: begin
                    if (cnt_q == ONE) begin
                        state_q <= S_RESTORE;
                        l_q     <= lifo_top;
                        if (ret_push_q) begin
                            stk_op_q   <= STK_PUSH;
                            stk_data_q <= ret_val_q;
                            d_q        <= d_q + ONE;
                        end
                    end else begin
                        stk_op_q <= STK_POP;
                        d_q      <= d_q - ONE;
                        cnt_q    <= cnt_q - ONE;
                    end
                end
`endif
                S_ISSUE, S_RESTORE: state_q <= S_CHECK;
                S_CHECK: begin
                    state_q   <= S_IDLE;
                    rsp_tos_q <= stk_tos;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign exp_status = (d_q == l_q) ? STS_EMPTY : STS_NONE;

    assign cmd_ready           = (state_q == S_IDLE);
    assign rsp_valid           = (state_q == S_CHECK);
    // Status returned by the stack is only meaningful in CHECK, the cycle after the last op.
    assign rsp_err             = !rsp_valid             ? 3'd0 :
                                 (err_q != ERR_OK)      ? err_q :
                                 (stk_status != exp_status) ? ERR_DESYNC : ERR_OK;
    assign rsp_tos             = rsp_valid ? stk_tos : rsp_tos_q;
    assign stk_op              = stk_op_q;
    assign stk_data            = stk_data_q;
    assign stk_underflow_limit = l_q;
    assign depth               = d_q;

endmodule
